// File: rtl/ddr4_phy_iob_byte_seq.sv
// DDR4 PHY byte-lane IOB sequencer: write-burst tristate/ODT windowing plus VREF tune ramp.
// Optional status logic (wr_ovf, wr_burst_cnt) is enabled by defining IOB_BYTE_SEQ_STATUS_EN.
module ddr4_phy_iob_byte_seq #(
    parameter int                    NUM_BITS      = 13,
    parameter logic [3*NUM_BITS-1:0] IOBTYPE       = '0,
    parameter int                    PRE_CYC       = 1,
    parameter int                    POST_CYC      = 1,
    parameter int                    VREF_STEP_CYC = 16,
    parameter logic [6:0]            VREF_INIT     = 7'h30
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_req,
    input  logic [7:0]          wr_len,
    output logic                wr_busy,
    output logic [NUM_BITS-1:0] phy2iob_t,
    output logic [NUM_BITS-1:0] phy2iob_odt_out_byte,
    input  logic [6:0]          vref_target,
    input  logic                vref_load,
    output logic [6:0]          fpga_vref_tune,
    output logic                vref_settled,
    output logic                wr_ovf,
    output logic [15:0]         wr_burst_cnt
);

    function automatic logic [NUM_BITS-1:0] pin_mask(input logic want_io);
        logic [NUM_BITS-1:0] m;
        logic [2:0]          c;
        m = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            c = IOBTYPE[3*i +: 3];
            if (want_io) m[i] = (c == 3'b011) || (c == 3'b111);
            else         m[i] = (c == 3'b001) || (c == 3'b101);
        end
        return m;
    endfunction

    localparam logic [NUM_BITS-1:0] IO_MASK  = pin_mask(1'b1);
    localparam logic [NUM_BITS-1:0] OUT_MASK = pin_mask(1'b0);
    // Output-only pins always drive; inout pins join them only inside the burst window.
    localparam logic [NUM_BITS-1:0] T_IDLE   = ~OUT_MASK;
    localparam logic [NUM_BITS-1:0] T_BUSY   = ~(OUT_MASK | IO_MASK);
    localparam logic [7:0]          PRE_LAST  = 8'(PRE_CYC - 1);
    localparam logic [7:0]          POST_LAST = 8'(POST_CYC - 1);
    localparam logic [7:0]          STEP_LAST = 8'(VREF_STEP_CYC - 1);

    typedef enum logic [1:0] {IDLE, PRE, BURST, POST} state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          len_q, len_d;
    logic                busy_q, busy_d;
    logic [NUM_BITS-1:0] t_q, t_d;
    logic [NUM_BITS-1:0] odt_q, odt_d;
    logic                accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        accept  = wr_req && (wr_len != 8'd0) && (state_q == IDLE);
        case (state_q)
            IDLE: if (accept) begin
                len_d = wr_len;
                if (PRE_CYC != 0) begin
                    state_d = PRE;
                    cnt_d   = PRE_LAST;
                end else begin
                    state_d = BURST;
                    cnt_d   = wr_len - 8'd1;
                end
            end
            PRE: if (cnt_q == 8'd0) begin
                state_d = BURST;
                cnt_d   = len_q - 8'd1;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            BURST: if (cnt_q == 8'd0) begin
                if (POST_CYC != 0) begin
                    state_d = POST;
                    cnt_d   = POST_LAST;
                end else begin
                    state_d = IDLE;
                end
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            POST: if (cnt_q == 8'd0) state_d = IDLE;
                  else cnt_d = cnt_q - 8'd1;
            default: state_d = IDLE;
        endcase
        // Outputs follow the next state so they are registered yet aligned with it.
        busy_d = (state_d != IDLE);
        t_d    = busy_d ? T_BUSY : T_IDLE;
        odt_d  = ~t_d & (OUT_MASK | IO_MASK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            len_q   <= 8'd0;
            busy_q  <= 1'b0;
            t_q     <= T_IDLE;
            odt_q   <= OUT_MASK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            busy_q  <= busy_d;
            t_q     <= t_d;
            odt_q   <= odt_d;
        end
    end

    assign wr_busy              = busy_q;
    assign phy2iob_t            = t_q;
    assign phy2iob_odt_out_byte = odt_q;

    logic [6:0] tune_q, tune_d;
    logic [6:0] tgt_q, tgt_d;
    logic [7:0] step_q, step_d;
    logic       settled_q, settled_d;

    always_comb begin
        tune_d = tune_q;
        tgt_d  = tgt_q;
        step_d = step_q;
        // A load retargets and restarts the step interval from the current code.
        if (vref_load) begin
            tgt_d  = vref_target;
            step_d = 8'd0;
        end else if (step_q == STEP_LAST) begin
            step_d = 8'd0;
            if (tune_q < tgt_q && tune_q != 7'h7F)      tune_d = tune_q + 7'd1;
            else if (tune_q > tgt_q && tune_q != 7'h00) tune_d = tune_q - 7'd1;
        end else begin
            step_d = step_q + 8'd1;
        end
        settled_d = (tune_q == tgt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tune_q    <= VREF_INIT;
            tgt_q     <= VREF_INIT;
            step_q    <= 8'd0;
            settled_q <= 1'b1;
        end else begin
            tune_q    <= tune_d;
            tgt_q     <= tgt_d;
            step_q    <= step_d;
            settled_q <= settled_d;
        end
    end

    assign fpga_vref_tune = tune_q;
    assign vref_settled   = settled_q;

`ifdef IOB_BYTE_SEQ_STATUS_EN
    logic        ovf_q, ovf_d;
    logic [15:0] bcnt_q, bcnt_d;

    always_comb begin
        ovf_d  = ovf_q | (wr_req && (wr_len != 8'd0) && busy_q);
        bcnt_d = (accept && bcnt_q != 16'hFFFF) ? bcnt_q + 16'd1 : bcnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            bcnt_q <= 16'd0;
        end else begin
            ovf_q  <= ovf_d;
            bcnt_q <= bcnt_d;
        end
    end

    assign wr_ovf       = ovf_q;
    assign wr_burst_cnt = bcnt_q;
`else
    assign wr_ovf       = 1'b0;
    assign wr_burst_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_ddr4_phy_iob_byte_seq.sv
// Directed bench for ddr4_phy_iob_byte_seq: one DUT with pre/postamble, one without.
module tb_ddr4_phy_iob_byte_seq;

`ifdef IOB_BYTE_SEQ_STATUS_EN
    localparam logic STATUS_EN = 1'b1;
`else
    localparam logic STATUS_EN = 1'b0;
`endif
    // pin3 inout(111), pin2 input(000), pin1 output(001), pin0 inout(011)
    localparam logic [11:0] TYPES  = 12'b111_000_001_011;
    localparam logic [3:0]  T_BUSY = 4'b0100;
    localparam logic [3:0]  T_IDLE = 4'b1101;
    localparam logic [3:0]  O_BUSY = 4'b1011;
    localparam logic [3:0]  O_IDLE = 4'b0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_req_a = 1'b0, wr_req_b = 1'b0;
    logic [7:0]  wr_len_a = 8'd0, wr_len_b = 8'd0;
    logic [6:0]  vref_target = 7'h30, vref_target_b = 7'h30;
    logic        vref_load = 1'b0, vref_load_b = 1'b0;

    logic        busy_a, busy_b, settled_a, settled_b, ovf_a, ovf_b;
    logic [3:0]  t_a, t_b, odt_a, odt_b;
    logic [6:0]  tune_a, tune_b;
    logic [15:0] cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ddr4_phy_iob_byte_seq #(.NUM_BITS(4), .IOBTYPE(TYPES), .PRE_CYC(1), .POST_CYC(1),
                            .VREF_STEP_CYC(16), .VREF_INIT(7'h30)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req_a), .wr_len(wr_len_a), .wr_busy(busy_a),
        .phy2iob_t(t_a), .phy2iob_odt_out_byte(odt_a), .vref_target(vref_target),
        .vref_load(vref_load), .fpga_vref_tune(tune_a), .vref_settled(settled_a),
        .wr_ovf(ovf_a), .wr_burst_cnt(cnt_a));

    ddr4_phy_iob_byte_seq #(.NUM_BITS(4), .IOBTYPE(TYPES), .PRE_CYC(0), .POST_CYC(0),
                            .VREF_STEP_CYC(16), .VREF_INIT(7'h30)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req_b), .wr_len(wr_len_b), .wr_busy(busy_b),
        .phy2iob_t(t_b), .phy2iob_odt_out_byte(odt_b), .vref_target(vref_target_b),
        .vref_load(vref_load_b), .fpga_vref_tune(tune_b), .vref_settled(settled_b),
        .wr_ovf(ovf_b), .wr_burst_cnt(cnt_b));

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_a); end
        checks++; if (t_a !== T_IDLE) begin errors++; $display("FAIL rst_t got=%b exp=%b", t_a, T_IDLE); end
        checks++; if (odt_a !== O_IDLE) begin errors++; $display("FAIL rst_odt got=%b exp=%b", odt_a, O_IDLE); end
        checks++; if (tune_a !== 7'h30) begin errors++; $display("FAIL rst_tune got=%h exp=30", tune_a); end
        checks++; if (settled_a !== 1'b1) begin errors++; $display("FAIL rst_settled got=%b exp=1", settled_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", ovf_a); end
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", cnt_a); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_window_pre_post();
        int n;
        wr_req_a = 1'b1; wr_len_a = 8'd4;
        @(negedge clk);
        wr_req_a = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL win_a_start got=%b exp=1", busy_a); end
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            checks++; if (t_a !== T_BUSY) begin errors++; $display("FAIL win_a_t got=%b exp=%b", t_a, T_BUSY); end
            checks++; if (odt_a !== O_BUSY) begin errors++; $display("FAIL win_a_odt got=%b exp=%b", odt_a, O_BUSY); end
            n++;
            @(negedge clk);
        end
        checks++; if (n != 6) begin errors++; $display("FAIL win_a_len got=%0d exp=6", n); end
        checks++; if (t_a !== T_IDLE) begin errors++; $display("FAIL win_a_t_idle got=%b exp=%b", t_a, T_IDLE); end
        checks++; if (odt_a !== O_IDLE) begin errors++; $display("FAIL win_a_odt_idle got=%b exp=%b", odt_a, O_IDLE); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_window_no_pre_post();
        int n;
        wr_req_b = 1'b1; wr_len_b = 8'd1;
        @(negedge clk);
        wr_req_b = 1'b0;
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            checks++; if (t_b !== T_BUSY) begin errors++; $display("FAIL win_b_t got=%b exp=%b", t_b, T_BUSY); end
            n++;
            @(negedge clk);
        end
        checks++; if (n != 1) begin errors++; $display("FAIL win_b_len got=%0d exp=1", n); end
        @(negedge clk);
        wr_req_b = 1'b1; wr_len_b = 8'd0;
        @(negedge clk);
        wr_req_b = 1'b0;
        n = 0;
        repeat (5) begin
            if (busy_b === 1'b1 || t_b !== T_IDLE) n++;
            @(negedge clk);
        end
        checks++; if (n != 0) begin errors++; $display("FAIL len0_window got=%0d busy cycles exp=0", n); end
        checks++; if (ovf_b !== 1'b0) begin errors++; $display("FAIL len0_ovf got=%b exp=0", ovf_b); end
    endtask

    task automatic test_back_to_back();
        int n;
        wr_req_a = 1'b1; wr_len_a = 8'd2;
        @(negedge clk);
        wr_req_a = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin n++; @(negedge clk); end
        checks++; if (n != 4) begin errors++; $display("FAIL b2b_first got=%0d exp=4", n); end
        wr_req_a = 1'b1; wr_len_a = 8'd1;
        @(negedge clk);
        wr_req_a = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy_a); end
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin n++; @(negedge clk); end
        checks++; if (n != 3) begin errors++; $display("FAIL b2b_second got=%0d exp=3", n); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL b2b_ovf got=%b exp=0", ovf_a); end
        @(negedge clk);
    endtask

    task automatic test_overflow();
        int n;
        wr_req_a = 1'b1; wr_len_a = 8'd4;
        @(negedge clk);
        wr_req_a = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            n++;
            // n==2 lands in the middle of the data phase
            wr_req_a = (n == 2);
            wr_len_a = (n == 2) ? 8'd2 : 8'd4;
            @(negedge clk);
        end
        wr_req_a = 1'b0;
        checks++; if (n != 6) begin errors++; $display("FAIL ovf_window got=%0d exp=6", n); end
        checks++; if (ovf_a !== STATUS_EN) begin errors++; $display("FAIL ovf_flag got=%b exp=%b", ovf_a, STATUS_EN); end
        repeat (3) @(negedge clk);
        checks++; if (ovf_a !== STATUS_EN) begin errors++; $display("FAIL ovf_sticky got=%b exp=%b", ovf_a, STATUS_EN); end
    endtask

    task automatic test_status_count();
        checks++; if (cnt_a !== (STATUS_EN ? 16'd4 : 16'd0))
            begin errors++; $display("FAIL cnt_a got=%0d exp=%0d", cnt_a, STATUS_EN ? 4 : 0); end
        checks++; if (cnt_b !== (STATUS_EN ? 16'd1 : 16'd0))
            begin errors++; $display("FAIL cnt_b got=%0d exp=%0d", cnt_b, STATUS_EN ? 1 : 0); end
    endtask

    task automatic test_vref_ramp();
        logic [6:0] exp_tune;
        logic       exp_set;
        int         steps;
        vref_target = 7'h34; vref_load = 1'b1;
        @(negedge clk);
        vref_load = 1'b0;
        for (int j = 0; j <= 66; j++) begin
            steps    = (j / 16 > 4) ? 4 : j / 16;
            exp_tune = 7'h30 + 7'(steps);
            exp_set  = (j == 0) || (j >= 65);
            checks++; if (tune_a !== exp_tune) begin errors++; $display("FAIL ramp_tune j=%0d got=%h exp=%h", j, tune_a, exp_tune); end
            checks++; if (settled_a !== exp_set) begin errors++; $display("FAIL ramp_settled j=%0d got=%b exp=%b", j, settled_a, exp_set); end
            @(negedge clk);
        end
    endtask

    task automatic test_vref_retarget();
        logic [6:0] exp_tune;
        int         steps;
        vref_target = 7'h30; vref_load = 1'b1;
        @(negedge clk);
        vref_load = 1'b0;
        // From 0x34 the 4th step down lands on 0x30; instead ramp up again from a fresh 0x30 start
        vref_target = 7'h34;
        repeat (70) @(negedge clk);
        checks++; if (tune_a !== 7'h30) begin errors++; $display("FAIL retgt_base got=%h exp=30", tune_a); end
        vref_load = 1'b1;
        @(negedge clk);
        vref_load = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (tune_a !== 7'h32) begin errors++; $display("FAIL retgt_mid got=%h exp=32", tune_a); end
        vref_target = 7'h2E; vref_load = 1'b1;
        @(negedge clk);
        vref_load = 1'b0;
        for (int j = 0; j <= 66; j++) begin
            steps    = (j / 16 > 4) ? 4 : j / 16;
            exp_tune = 7'h32 - 7'(steps);
            checks++; if (tune_a !== exp_tune) begin errors++; $display("FAIL retgt_tune j=%0d got=%h exp=%h", j, tune_a, exp_tune); end
            checks++; if (settled_a !== (j >= 65)) begin errors++; $display("FAIL retgt_settled j=%0d got=%b", j, settled_a); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        wr_req_a = 1'b1; wr_len_a = 8'd8;
        @(negedge clk);
        wr_req_a = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_pre_busy got=%b exp=1", busy_a); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL async_busy got=%b exp=0", busy_a); end
        checks++; if (t_a !== T_IDLE) begin errors++; $display("FAIL async_t got=%b exp=%b", t_a, T_IDLE); end
        checks++; if (odt_a !== O_IDLE) begin errors++; $display("FAIL async_odt got=%b exp=%b", odt_a, O_IDLE); end
        checks++; if (tune_a !== 7'h30) begin errors++; $display("FAIL async_tune got=%h exp=30", tune_a); end
        checks++; if (settled_a !== 1'b1) begin errors++; $display("FAIL async_settled got=%b exp=1", settled_a); end
        checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL async_ovf got=%b exp=0", ovf_a); end
        checks++; if (cnt_a !== 16'd0) begin errors++; $display("FAIL async_cnt got=%0d exp=0", cnt_a); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1; wr_req_a = 1'b1; wr_len_a = 8'd1;
        @(negedge clk);
        wr_req_a = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", busy_a); end
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin n++; @(negedge clk); end
        checks++; if (n != 3) begin errors++; $display("FAIL first_req_len got=%0d exp=3", n); end
    endtask

    initial begin
        test_reset();
        test_window_pre_post();
        test_window_no_pre_post();
        test_back_to_back();
        test_overflow();
        test_status_count();
        test_vref_ramp();
        test_vref_retarget();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr4_phy_iob_byte_seq.md
DDR4_PHY_IOB_BYTE_SEQ -- requirements
Module: ddr4_phy_iob_byte_seq

Interface
REQ-001 SHALL have parameter NUM_BITS, default 13: number of pins in the byte lane, legal range 1..16.
REQ-002 SHALL have parameter IOBTYPE, width 3*NUM_BITS, default 0: per-pin dio type code; 011 and 111 are inout, 001 and 101 are output-only, all other codes are input or unused.
REQ-003 SHALL have parameter PRE_CYC, default 1: write preamble cycles, legal range 0..7.
REQ-004 SHALL have parameter POST_CYC, default 1: write postamble cycles, legal range 0..7.
REQ-005 SHALL have parameter VREF_STEP_CYC, default 16: cycles between VREF tune steps, legal range 1..255.
REQ-006 SHALL have parameter VREF_INIT, default 7'h30: VREF tune code after reset.
REQ-007 SHALL provide port: clk, input, 1, the only clock.
REQ-008 SHALL provide port: rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL provide port: wr_req, input, 1, one-cycle write-burst request.
REQ-010 SHALL provide port: wr_len, input, 8, burst length in cycles, sampled with wr_req.
REQ-011 SHALL provide port: wr_busy, output, 1, high while a burst window is active.
REQ-012 SHALL provide port: phy2iob_t, output, NUM_BITS, per-pin tristate (1 = high-Z).
REQ-013 SHALL provide port: phy2iob_odt_out_byte, output, NUM_BITS, per-pin DCI termination disable.
REQ-014 SHALL provide port: vref_target, input, 7, target VREF code.
REQ-015 SHALL provide port: vref_load, input, 1, latches vref_target.
REQ-016 SHALL provide port: fpga_vref_tune, output, 7, current VREF code.
REQ-017 SHALL provide port: vref_settled, output, 1, high when fpga_vref_tune equals the latched target.
REQ-018 SHALL provide port: wr_ovf, output, 1, sticky flag for a request rejected while busy.
REQ-019 SHALL provide port: wr_burst_cnt, output, 16, count of accepted bursts.

Function
REQ-020 SHALL run a burst FSM with states IDLE, PRE, BURST and POST; PRE is skipped when PRE_CYC=0 and POST is skipped when POST_CYC=0.
REQ-021 SHALL accept wr_req only in IDLE with wr_len!=0; wr_req with wr_len=0 SHALL be ignored and SHALL NOT set wr_ovf.
REQ-022 SHALL set wr_busy from the edge after acceptance for exactly PRE_CYC+wr_len+POST_CYC cycles, then return to IDLE.
REQ-023 SHALL drive inout pins with t=0 and odt=1 exactly while wr_busy=1, and with t=1 and odt=0 otherwise.
REQ-024 SHALL drive output-only pins constantly with t=0 and odt=1, and input or unused pins constantly with t=1 and odt=0.
REQ-025 SHALL register all outputs, with no combinational path from any input to any output.
REQ-026 SHALL treat wr_req while wr_busy=1 as ignored and set wr_ovf, with no effect on the current burst.
REQ-027 SHALL accept a wr_req in the first IDLE cycle after POST, so back-to-back bursts have exactly one idle cycle between windows.
REQ-028 SHALL latch vref_target on vref_load and restart the step counter.
REQ-029 SHALL step fpga_vref_tune by +1 or -1 toward the latched target every VREF_STEP_CYC cycles, with no wrap: 7'h7F stays saturated and 7'h00 stays saturated.
REQ-030 SHALL retarget on a vref_load arriving mid-ramp, stepping from the current code with the first step VREF_STEP_CYC cycles after the load.
REQ-031 SHALL update vref_settled registered, one cycle after equality changes.

Reset
REQ-032 SHALL, on rst_n low and asynchronously, return the FSM to IDLE and set wr_busy=0, inout and input pins t=1/odt=0, output pins t=0/odt=1, fpga_vref_tune=VREF_INIT, latched target=VREF_INIT, vref_settled=1, wr_ovf=0 and wr_burst_cnt=0.
REQ-033 SHALL abort any burst in progress on reset, with no postamble.
REQ-034 SHALL release reset synchronously to clk; the first request is accepted in the first cycle after rst_n rises.

Configuration
REQ-035 SHALL use the macro IOB_BYTE_SEQ_STATUS_EN: when defined, wr_ovf is implemented sticky until reset and wr_burst_cnt increments on each accepted burst, saturating at 16'hFFFF.
REQ-036 SHALL, when IOB_BYTE_SEQ_STATUS_EN is undefined, keep the wr_ovf and wr_burst_cnt ports present and tie them to 0, with no status logic.

Verification
REQ-037 SHALL verify: PRE=1, POST=1, wr_req with wr_len=4 -> wr_busy and inout t=0 for exactly 6 cycles starting one edge after the request; output-only pin t stays 0 throughout.
REQ-038 SHALL verify: PRE=0, POST=0, wr_len=1 -> 1-cycle window; wr_len=0 -> no window and wr_ovf stays 0.
REQ-039 SHALL verify: wr_req during BURST -> window length unchanged and wr_ovf=1 (with the macro) or 0 (without it).
REQ-040 SHALL verify: vref_target=0x34 loaded from 0x30 with VREF_STEP_CYC=16 -> codes 31, 32, 33, 34 at 16-cycle intervals; vref_settled rises one cycle after reaching 0x34.
REQ-041 SHALL verify: retarget to 0x2E mid-ramp at code 0x32 -> descending steps from 0x32 with the first step 16 cycles after the load.
REQ-042 SHALL verify: rst_n low mid-BURST -> immediate t=1 on inout pins, wr_busy=0 and fpga_vref_tune=0x30 with no clock edge required.
